irq_controller: RTL
===================

# irq_controller

Eight-line priority interrupt controller that sits between peripheral request lines and the core's `irq`/`intr`/`intl` toggle handshake. It latches rising-edge requests and applies a mask and in-service nesting. It then presents one vector at a time to the core. A small I/O register file on the core's port bus provides mask, vector base, status readback and end-of-interrupt (EOI) commands.

## Interface
Parameters:
- `PORT_BASE`, 16'h0020: I/O address of register 0. Registers 1 and 2 sit at `PORT_BASE+1` and `PORT_BASE+2`; all 16 address bits are decoded.
- `VEC_RESET`, 8'h08: reset value of the vector base register. Bits [2:0] are ignored.

Ports:
- `clock` in 1: single clock domain for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `irq_line` in 8: request lines, synchronous to `clock`, rising-edge triggered. Line 0 has the highest priority.
- `port` in 16: I/O address.
- `port_w` in 1: one-cycle write strobe.
- `port_r` in 1: one-cycle read strobe.
- `port_o` in 8: write data from the core.
- `port_i` out 8: read data to the core, registered.
- `irq` out 8: interrupt vector, stable while a request is outstanding.
- `intr` out 1: request toggle. A request is outstanding while `intr != intl`.
- `intl` in 1: acknowledge toggle from the core. The core copies `intr` into `intl` when it takes the interrupt.

## Operation
Registers:
- IRR (pending requests), ISR (in service), IMR (mask), VB (vector base, bits [7:3]).
- `irq_prev` holds last cycle's `irq_line`.

Request latching:
- Every cycle, IRR |= `irq_line & ~irq_prev`.

Eligibility and selection:
- Line n is eligible when IRR[n]=1, IMR[n]=0, and ISR has no bit set at any index ≤ n.
- The selected line `sel` is the lowest-index eligible line.

State machine:
- SYNC (entered on reset release): `intr <= intl`, go to IDLE. The core's reset does not clear `intl`, so this step is mandatory.
- IDLE: if any line is eligible, then:
  - `irq <= {VB[7:3], sel}`;
  - `cur <= sel`;
  - `intr <= ~intr`;
  - go to WAIT.
- WAIT: hold `irq` and `intr`. When `intr == intl`:
  - ISR[cur] <= 1;
  - IRR[cur] <= 0;
  - go to IDLE.
- Once raised, a request is always delivered. Masking line `cur` while in WAIT does not retract it.

Port writes (on `port_w`):
- Address `PORT_BASE`, data 8'h20: non-specific EOI. Clears the lowest-index set ISR bit. No effect if ISR=0.
- Address `PORT_BASE`, data 8'b0110_0nnn: specific EOI. Clears ISR[n].
- Address `PORT_BASE`, any other data: ignored.
- Address `PORT_BASE+1`: IMR <= data.
- Address `PORT_BASE+2`: VB <= data[7:3].

Port reads (on `port_r`, data appears one cycle later and holds until the next read):
- `PORT_BASE` returns ISR.
- `PORT_BASE+1` returns IMR.
- `PORT_BASE+2` returns IRR.
- Unmapped addresses return 8'hFF.

Simultaneous events:
- IRR next = (IRR & ~ack_clr) | edge_set. A new edge on line `cur` in the ack cycle re-pends it.
- ISR next = (ISR & ~eoi_clr) | ack_set. A non-specific EOI evaluates the ISR value from before the update, so an ack and an EOI in the same cycle both take effect.
- An IMR write takes effect in the following cycle's eligibility check.

## Timing
Reset values (all applied asynchronously while `reset_n`=0):
- State = SYNC.
- IRR = 0, ISR = 0, `irq_prev` = 0.
- IMR = 8'hFF.
- VB = `VEC_RESET[7:3]`.
- `intr` = 0, `irq` = 8'h00, `port_i` = 8'hFF.

Latencies:
- `irq_line[n]` rises in cycle 0 → IRR[n] visible in cycle 1 → `intr` toggles and `irq` is valid at the edge ending cycle 1. Two clocks in total.
- `intl` matches `intr` in cycle k → ISR and IRR update at the end of cycle k → the next request can toggle at the end of cycle k+1 at the earliest.
- `irq` is valid no later than the `intr` toggle and is held until the acknowledge is seen.
- Reset asserted mid-WAIT abandons the request. SYNC then realigns `intr` with `intl`, so no spurious interrupt is presented after reset.

## Test plan
- Reset release with `intl`=1 → after SYNC, `intr`=1; no `intr != intl` condition ever occurs while IRR=0.
- Write IMR=8'h00 and VB=8'h20, then pulse `irq_line[3]` → `intr` toggles 2 clocks later with `irq`=8'h23. Echo `intl` → ISR reads 8'h08 and IRR reads 8'h00.
- With line 3 in service, pulse lines 5 and 1 together → only the vector for line 1 is presented. Line 5 stays pending; after two non-specific EOIs (8'h20), line 5 is delivered with `irq`=8'h25.
- IMR=8'hFE, pulse line 2 → no `intr` toggle and IRR=8'h04. Write IMR=8'h00 → toggle occurs on the second cycle after the write.
- Specific EOI 8'h63 written in the same cycle as the acknowledge of line 0 → ISR ends at 8'h01 with bit 3 cleared.
- Assert `reset_n` during WAIT → all registers return to their reset values, `intr`=0 immediately; after release, `intr` equals `intl`.

Source files
------------

// File: rtl/irq_controller.sv
// Eight-line priority interrupt controller: edge-latched requests, mask, in-service
// nesting, and an intr/intl toggle handshake toward the core with a small port-mapped register file.
module irq_controller #(
    parameter logic [15:0] PORT_BASE = 16'h0020,
    parameter logic [7:0]  VEC_RESET = 8'h08
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  irq_line,
    input  logic [15:0] port,
    input  logic        port_w,
    input  logic        port_r,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_i,
    output logic [7:0]  irq,
    output logic        intr,
    input  logic        intl
);

    localparam int unsigned NLINES = 8;
    localparam int unsigned IDXW   = 3;
    localparam int unsigned VBW    = 5;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NLINES-1:0]   irr_q, irr_d;
    logic [NLINES-1:0]   isr_q, isr_d;
    logic [NLINES-1:0]   imr_q, imr_d;
    logic [VBW-1:0]      vb_q, vb_d;
    logic [NLINES-1:0]   irq_prev_q;
    logic [IDXW-1:0]     cur_q, cur_d;
    logic                intr_q, intr_d;
    logic [7:0]          irq_q, irq_d;
    logic [7:0]          port_i_q, port_i_d;

    logic [NLINES-1:0]   isr_blk;
    logic [NLINES-1:0]   elig;
    logic                any_elig;
    logic [IDXW-1:0]     sel;
    logic                ack_c;
    logic [NLINES-1:0]   ack_mask;
    logic                addr_r0, addr_r1, addr_r2;
    logic                eoi_ns, eoi_sp;
    logic [NLINES-1:0]   eoi_clr;

    // A line is blocked by any in-service line of equal or higher priority.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        isr_blk = '0;
        for (int i = 0; i < NLINES; i++) begin
            acc        = acc | isr_q[i];
            isr_blk[i] = acc;
        end
        elig     = irr_q & ~imr_q & ~isr_blk;
        any_elig = |elig;
        sel      = '0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel = IDXW'(i);
            end
        end
    end

    always_comb begin
        addr_r0 = (port == PORT_BASE);
        addr_r1 = (port == PORT_BASE + 16'd1);
        addr_r2 = (port == PORT_BASE + 16'd2);
        eoi_ns  = port_w && addr_r0 && (port_o == 8'h20);
        eoi_sp  = port_w && addr_r0 && (port_o[7:3] == 5'b01100);
        eoi_clr = '0;
        if (eoi_ns) begin
            eoi_clr = isr_q & (~isr_q + 8'd1);
        end else if (eoi_sp) begin
            eoi_clr = 8'd1 << port_o[2:0];
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: state_d = ST_IDLE;
            ST_IDLE: if (any_elig) state_d = ST_WAIT;
            ST_WAIT: if (intr_q == intl) state_d = ST_IDLE;
            default: state_d = ST_SYNC;
        endcase
    end

    // Output/handshake logic.
    always_comb begin
        intr_d   = intr_q;
        irq_d    = irq_q;
        cur_d    = cur_q;
        ack_c    = 1'b0;
        case (state_q)
            ST_SYNC: intr_d = intl;
            ST_IDLE: begin
                if (any_elig) begin
                    irq_d  = {vb_q, sel};
                    cur_d  = sel;
                    intr_d = ~intr_q;
                end
            end
            ST_WAIT: ack_c = (intr_q == intl);
            default: intr_d = intl;
        endcase
        ack_mask = ack_c ? (8'd1 << cur_q) : 8'd0;
    end

    // Register file and request bookkeeping.
    always_comb begin
        irr_d    = (irr_q & ~ack_mask) | (irq_line & ~irq_prev_q);
        isr_d    = (isr_q & ~eoi_clr) | ack_mask;
        imr_d    = imr_q;
        vb_d     = vb_q;
        port_i_d = port_i_q;
        if (port_w && addr_r1) imr_d = port_o;
        if (port_w && addr_r2) vb_d  = port_o[7:3];
        if (port_r) begin
            if (addr_r0)      port_i_d = isr_q;
            else if (addr_r1) port_i_d = imr_q;
            else if (addr_r2) port_i_d = irr_q;
            else              port_i_d = 8'hFF;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irr_q      <= '0;
            isr_q      <= '0;
            imr_q      <= 8'hFF;
            vb_q       <= VEC_RESET[7:3];
            irq_prev_q <= '0;
            cur_q      <= '0;
            intr_q     <= 1'b0;
            irq_q      <= 8'h00;
            port_i_q   <= 8'hFF;
        end else begin
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            imr_q      <= imr_d;
            vb_q       <= vb_d;
            irq_prev_q <= irq_line;
            cur_q      <= cur_d;
            intr_q     <= intr_d;
            irq_q      <= irq_d;
            port_i_q   <= port_i_d;
        end
    end

    assign port_i = port_i_q;
    assign irq    = irq_q;
    assign intr   = intr_q;

endmodule
